// File: rtl/fpu_pkg.sv
// Shared FPU types: result status, normalizer FSM states, format constants.
// Team word: sign[31], biased exponent[30:21] (bias 511), fraction[20:0].
package fpu_pkg;

    localparam int EXP_W   = 10;
    localparam int FRAC_W  = 21;
    localparam int BIAS    = 511;
    localparam int EXP_MAX = 1023;
    localparam int WORD_W  = 1 + EXP_W + FRAC_W;

    typedef enum logic [3:0] {
        OVERFLOW  = 4'd0,
        UNDERFLOW = 4'd1,
        EXACT     = 4'd2,
        INEXACT   = 4'd3
    } status_t;

    typedef enum logic [1:0] {
        IDLE,
        NORMALIZE,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even of a normalized {hidden, fraction, G, R, S}
// significand; a carry out of the fraction bumps the exponent.
module fpu_round_rne
    import fpu_pkg::*;
#(
    parameter int EXP_W  = fpu_pkg::EXP_W,
    parameter int FRAC_W = fpu_pkg::FRAC_W
) (
    input  logic [FRAC_W+3:0]        mant,
    input  logic signed [EXP_W+2:0]  exp_in,
    output logic [FRAC_W-1:0]        frac,
    output logic signed [EXP_W+2:0]  exp_adj,
    output logic                     inexact
);

    logic lsb;
    logic guard;
    logic rnd;
    logic sticky;
    logic up;
    logic carry;

    assign lsb    = mant[3];
    assign guard  = mant[2];
    assign rnd    = mant[1];
    assign sticky = mant[0];

    assign up      = guard & (rnd | sticky | lsb);
    assign inexact = guard | rnd | sticky;

    // all-ones significand plus one wraps the fraction to zero: 1.0 * 2
    assign carry = up & (&mant[FRAC_W+3:3]);
    assign frac  = mant[FRAC_W+2:3] + FRAC_W'(up);

    assign exp_adj = exp_in + {{(EXP_W+2){1'b0}}, carry};

endmodule

// File: rtl/fpu_normalize_pack.sv
// FPU back end: bit-serial normalize, RNE round, range classify and pack.
// Start/busy/done handshake; one shift per clock in NORMALIZE.
module fpu_normalize_pack
    import fpu_pkg::*;
#(
    parameter int EXP_W  = fpu_pkg::EXP_W,
    parameter int FRAC_W = fpu_pkg::FRAC_W
) (
    input  logic                     clock_100Khz,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     sign_in,
    input  logic signed [EXP_W+1:0]  exp_in,
    input  logic [FRAC_W+4:0]        mant_in,
    output logic                     busy,
    output logic                     done,
    output logic [EXP_W+FRAC_W:0]    data_out,
    output status_t                  status_out
);

    localparam int MW = FRAC_W + 5;
    localparam int XW = EXP_W + 3;
    localparam int TOP_I = (1 << EXP_W) - 1;

    localparam logic signed [XW-1:0] EXP_TOP = XW'(TOP_I);
    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

    state_t state;
    state_t state_nx;

    logic                  sign_r;
    logic signed [XW-1:0]  exp_r;
    logic [MW-1:0]         mant_r;

    logic [FRAC_W-1:0]     frac;
    logic signed [XW-1:0]  exp_adj;
    logic                  inexact;

    logic [EXP_W+FRAC_W:0] pack_word;
    status_t               pack_st;

    fpu_round_rne #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round (
        .mant    (mant_r[MW-2:0]),
        .exp_in  (exp_r),
        .frac    (frac),
        .exp_adj (exp_adj),
        .inexact (inexact)
    );

    always_ff @(posedge clock_100Khz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // zero operand skips NORMALIZE; ROUND packs it as a signed zero
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (mant_in == '0) ? ROUND : NORMALIZE;
                end
            end
            NORMALIZE: begin
                if (!mant_r[MW-1] && mant_r[MW-2]) begin
                    state_nx = ROUND;
                end
            end
            ROUND:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clock_100Khz or posedge reset) begin
        if (reset) begin
            sign_r <= 1'b0;
            exp_r  <= '0;
            mant_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_r <= sign_in;
                        exp_r  <= {exp_in[EXP_W+1], exp_in};
                        mant_r <= mant_in;
                    end
                end
                NORMALIZE: begin
                    if (mant_r[MW-1]) begin
                        mant_r <= {1'b0, mant_r[MW-1:2],
                                   mant_r[1] | mant_r[0]};
                        exp_r  <= exp_r + XW'(1);
                    end else if (!mant_r[MW-2]) begin
                        mant_r <= {mant_r[MW-2:0], 1'b0};
                        exp_r  <= exp_r - XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pack_word = '0;
        pack_st   = EXACT;
        if (mant_r == '0) begin
            pack_word = {sign_r, {(EXP_W+FRAC_W){1'b0}}};
        end else if (exp_adj >= EXP_TOP) begin
            pack_word = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            pack_st   = OVERFLOW;
        end else if (exp_adj < EXP_ONE) begin
            pack_word = {sign_r, {(EXP_W+FRAC_W){1'b0}}};
            pack_st   = UNDERFLOW;
        end else begin
            pack_word = {sign_r, exp_adj[EXP_W-1:0], frac};
            pack_st   = inexact ? INEXACT : EXACT;
        end
    end

    always_ff @(posedge clock_100Khz or posedge reset) begin
        if (reset) begin
            done       <= 1'b0;
            data_out   <= '0;
            status_out <= EXACT;
        end else begin
            done <= (state == ROUND);
            if (state == ROUND) begin
                data_out   <= pack_word;
                status_out <= pack_st;
            end
        end
    end

endmodule

// File: tb/tb_fpu_normalize_pack.sv
// Directed bench for fpu_normalize_pack with an expected-result queue.
// Results are popped and compared when done pulses.
module tb_fpu_normalize_pack;
    import fpu_pkg::*;

    logic               clock_100Khz = 1'b0;
    logic               reset;
    logic               start;
    logic               sign_in;
    logic signed [11:0] exp_in;
    logic [25:0]        mant_in;
    logic               busy;
    logic               done;
    logic [31:0]        data_out;
    status_t            status_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        status_t     st;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fpu_normalize_pack dut (
        .clock_100Khz (clock_100Khz),
        .reset        (reset),
        .start        (start),
        .sign_in      (sign_in),
        .exp_in       (exp_in),
        .mant_in      (mant_in),
        .busy         (busy),
        .done         (done),
        .data_out     (data_out),
        .status_out   (status_out)
    );

    always #5 clock_100Khz = ~clock_100Khz;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue one operation; lat counts edges after the sampling edge.
    task automatic issue(input string tag, input logic sgn,
                         input int ex, input logic [25:0] m,
                         input logic [31:0] d, input status_t st,
                         input int lat, input bit glitch);
        exp_t e;
        exp_t got;
        int   n;
        bit   seen;
        e.tag  = tag;
        e.data = d;
        e.st   = st;
        e.lat  = lat;
        sb.push_back(e);
        @(negedge clock_100Khz);
        sign_in = sgn;
        exp_in  = 12'(ex);
        mant_in = m;
        start   = 1'b1;
        @(posedge clock_100Khz);
        #1;
        start = 1'b0;
        n     = 0;
        seen  = done;
        while (!seen && n < 64) begin
            start = glitch && (n == 1);
            if (start) begin
                sign_in = ~sgn;
                mant_in = '0;
            end
            @(posedge clock_100Khz);
            #1;
            n++;
            seen = done;
        end
        start = 1'b0;
        got = sb.pop_front();
        chk({got.tag, "_done"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({got.tag, "_data"}, data_out, got.data);
            chk({got.tag, "_status"}, 32'(status_out), 32'(got.st));
            chk({got.tag, "_lat"}, 32'(n), 32'(got.lat));
        end
        @(posedge clock_100Khz);
        #1;
        chk({got.tag, "_done_drop"}, 32'(done), 32'd0);
        chk({got.tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        sign_in = 1'b0;
        exp_in  = '0;
        mant_in = '0;
        repeat (2) @(posedge clock_100Khz);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_status", 32'(status_out), 32'(EXACT));
        @(negedge clock_100Khz);
        reset = 1'b0;

        issue("unit", 1'b0, 511, 26'h1000000,
              32'h3FE00000, EXACT, 2, 1'b0);
        issue("carry_in", 1'b0, 511, 26'h2000000,
              32'h40000000, EXACT, 3, 1'b0);
        issue("lshift4", 1'b0, 515, 26'h0100000,
              32'h3FE00000, EXACT, 6, 1'b0);
        issue("rnd_carry", 1'b0, 511, 26'h1FFFFFC,
              32'h40000000, INEXACT, 2, 1'b0);
        issue("tie_even", 1'b0, 511, 26'h1000004,
              32'h3FE00000, INEXACT, 2, 1'b0);
        issue("tie_odd", 1'b0, 511, 26'h100000C,
              32'h3FE00002, INEXACT, 2, 1'b0);
        issue("sticky_rsh", 1'b0, 511, 26'h2000003,
              32'h40000000, INEXACT, 3, 1'b0);
        issue("grs_rsh", 1'b0, 511, 26'h200000C,
              32'h40000001, INEXACT, 3, 1'b0);
        issue("ovf", 1'b0, 1023, 26'h1000000,
              32'h7FE00000, OVERFLOW, 2, 1'b0);
        issue("ovf_rnd", 1'b1, 1022, 26'h1FFFFFC,
              32'hFFE00000, OVERFLOW, 2, 1'b0);
        issue("exp_one", 1'b0, 1, 26'h1000000,
              32'h00200000, EXACT, 2, 1'b0);
        issue("unf_zero", 1'b1, 0, 26'h1000000,
              32'h80000000, UNDERFLOW, 2, 1'b0);
        issue("unf_neg", 1'b0, -5, 26'h1000000,
              32'h00000000, UNDERFLOW, 2, 1'b0);
        issue("unf_lsh", 1'b0, 2, 26'h0400000,
              32'h00000000, UNDERFLOW, 4, 1'b0);
        issue("zero", 1'b1, 511, 26'h0000000,
              32'h80000000, EXACT, 1, 1'b0);
        issue("busy_start", 1'b0, 515, 26'h0100000,
              32'h3FE00000, EXACT, 6, 1'b1);

        // reset while normalizing
        @(negedge clock_100Khz);
        sign_in = 1'b0;
        exp_in  = 12'sd515;
        mant_in = 26'h0100000;
        start   = 1'b1;
        @(posedge clock_100Khz);
        #1;
        start = 1'b0;
        @(posedge clock_100Khz);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_data", data_out, 32'd0);
        chk("mid_rst_status", 32'(status_out), 32'(EXACT));
        @(negedge clock_100Khz);
        reset = 1'b0;

        issue("after_rst", 1'b0, 511, 26'h100000C,
              32'h3FE00002, INEXACT, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
